// File: rtl/reaction_timer_if.sv
// reaction_timer_if: player inputs and score/lamp outputs of the reaction timer
interface reaction_timer_if;
  logic       Start;
  logic       React;
  logic [3:0] S;
  logic [3:0] tS;
  logic [3:0] hS;
  logic [3:0] mS;
  logic       En_update;
  logic       Go;
  logic       Early;
  logic       Timeout;
  modport master (output Start, React, input S, tS, hS, mS, En_update, Go, Early, Timeout);
  modport slave  (input Start, React, output S, tS, hS, mS, En_update, Go, Early, Timeout);
endinterface

// File: rtl/reaction_timer.sv
// reaction_timer: round controller with pseudo-random GO delay and BCD millisecond timer
module reaction_timer #(
  parameter int TICK_DIV     = 50000,
  parameter int MIN_DELAY_MS = 1000
) (
  input logic            Clk,
  input logic            Rst,
  reaction_timer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, WAIT, TIMING, DONE} state_t;
  state_t        state;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic [13:0]   delay;
  logic          tick, m9, h9, t9, s9;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign m9   = bus.mS == 4'd9;
  assign h9   = bus.hS == 4'd9;
  assign t9   = bus.tS == 4'd9;
  assign s9   = bus.S == 4'd9;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state         <= IDLE;
      lfsr          <= 16'hACE1;
      presc         <= '0;
      delay         <= '0;
      bus.S         <= '0;
      bus.tS        <= '0;
      bus.hS        <= '0;
      bus.mS        <= '0;
      bus.En_update <= 1'b0;
      bus.Go        <= 1'b0;
      bus.Early     <= 1'b0;
      bus.Timeout   <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      presc         <= tick ? '0 : presc + 1'b1;
      bus.En_update <= 1'b0;
      case (state)
        IDLE, DONE:
          if (bus.Start) begin
            state       <= WAIT;
            delay       <= 14'(MIN_DELAY_MS) + 14'(lfsr[10:0]);
            presc       <= '0;
            bus.S       <= '0;
            bus.tS      <= '0;
            bus.hS      <= '0;
            bus.mS      <= '0;
            bus.Early   <= 1'b0;
            bus.Timeout <= 1'b0;
          end
        WAIT:
          if (bus.React) begin
            state     <= DONE;
            bus.Early <= 1'b1;
          end else if (tick) begin
            delay <= delay - 1'b1;
            if (delay == 14'd1) begin
              state  <= TIMING;
              bus.Go <= 1'b1;
              presc  <= '0;
            end
          end
        TIMING:
          // a React at 0000 would report the tracker's empty code, so it counts as a false start
          if (bus.React) begin
            state  <= DONE;
            bus.Go <= 1'b0;
            if ({bus.S, bus.tS, bus.hS, bus.mS} == 16'h0000) bus.Early <= 1'b1;
            else bus.En_update <= 1'b1;
          end else if (tick) begin
            if (s9 && t9 && h9 && m9) begin
              state       <= DONE;
              bus.Go      <= 1'b0;
              bus.Timeout <= 1'b1;
            end else begin
              bus.mS <= m9 ? 4'd0 : bus.mS + 4'd1;
              bus.hS <= m9 ? (h9 ? 4'd0 : bus.hS + 4'd1) : bus.hS;
              bus.tS <= (m9 && h9) ? (t9 ? 4'd0 : bus.tS + 4'd1) : bus.tS;
              bus.S  <= (m9 && h9 && t9) ? bus.S + 4'd1 : bus.S;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule
